load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_extend.sv | 30 +++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: default data width, funct3 size
// codes, FSM state encoding and the alignment-mask helper used when the
// optional misalignment trap is built in (macro MISALIGN_TRAP_EN).
package lsu_pkg;

    localparam int unsigned LSU_XLEN = 64;

    // funct3 size codes
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_align_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_align_mask = 3'b000;
            2'b01:   size_align_mask = 3'b001;
            2'b10:   size_align_mask = 3'b011;
            default: size_align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte select and sign/zero extension of a load word.
// Ports:
//   word   - memory word, bytes address..address+7 (little-endian)
//   funct3 - size code
//   result - extended load value (0 for the illegal code)
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = XLEN'($signed(word[7:0]));
            F3_H:    result = XLEN'($signed(word[15:0]));
            F3_W:    result = XLEN'($signed(word[31:0]));
            F3_D:    result = word;
            F3_BU:   result = XLEN'(word[7:0]);
            F3_HU:   result = XLEN'(word[15:0]);
            F3_WU:   result = XLEN'(word[31:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and performs it against a
// byte-addressed little-endian data memory. Sub-word stores use a
// read-modify-write of the addressed word. Optional macro MISALIGN_TRAP_EN
// turns non-size-aligned H/W/D accesses into error responses.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   req_*             - request handshake and payload (taken on valid && ready)
//   resp_*            - one-cycle completion pulse with load data / error flag
//   wrt_en, address,
//   write_data        - memory write strobe, byte address, write word
//   read_data         - combinational memory read word at address
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            wrt_en,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] write_data,
    input  logic [XLEN-1:0] read_data
);

    lsu_state_t      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] write_data_d;
    logic [XLEN-1:0] resp_rdata_d;
    logic            resp_err_d;
    logic            illegal;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] merged;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .word   (read_data),
        .funct3 (funct3_q),
        .result (load_value)
    );

    // Request legality: reserved code, unsigned store codes, optional misalignment.
    always_comb begin
        illegal = (req_funct3 == F3_ILL) || (req_store && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
        if ((req_addr[2:0] & size_align_mask(req_funct3)) != 3'b000) begin
            illegal = 1'b1;
        end
`else
        illegal = illegal;
`endif
    end

    // Sub-word store merge: low bytes from store data, upper bytes from memory.
    always_comb begin
        merged = read_data;
        case (funct3_q[1:0])
            2'b00:   merged[7:0]  = wdata_q[7:0];
            2'b01:   merged[15:0] = wdata_q[15:0];
            2'b10:   merged[31:0] = wdata_q[31:0];
            default: merged       = wdata_q;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        store_d      = store_q;
        wdata_d      = wdata_q;
        addr_d       = address;
        write_data_d = write_data;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    store_d  = req_store;
                    wdata_d  = req_wdata;
                    addr_d   = req_addr;
                    if (illegal) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_D) begin
                        state_d      = WRITE;
                        write_data_d = req_wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                resp_rdata_d = store_q ? '0 : load_value;
                state_d      = RESP;
            end
            RMW_RD: begin
                write_data_d = merged;
                state_d      = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; handshake/strobes decode the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            address    <= '0;
            write_data <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b0;
            wrt_en     <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            store_q    <= store_d;
            wdata_q    <= wdata_d;
            address    <= addr_d;
            write_data <= write_data_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            resp_valid <= (state_d == RESP);
            wrt_en     <= (state_d == WRITE);
            req_ready  <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 64-byte little-endian memory model.
module tb_load_store_unit;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            wrt_en;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;

    load_store_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .wrt_en     (wrt_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   last_wr_cyc = 0;
    int   resp_cnt = 0;

    logic [7:0] mem [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        read_data = '0;
        for (int k = 0; k < 8; k++) begin
            read_data[8*k +: 8] = mem[6'(address[5:0] + 6'(k))];
        end
    end

    always @(posedge clk) begin
        if (wrt_en) begin
            for (int k = 0; k < 8; k++) begin
                mem[6'(address[5:0] + 6'(k))] <= write_data[8*k +: 8];
            end
        end
    end

    // Monitor: count write strobes, pop and compare every response pulse.
    always @(negedge clk) begin
        if (rst && wrt_en) begin
            wr_cnt      = wr_cnt + 1;
            last_wr_cyc = cyc;
        end
        if (rst && resp_valid) begin
            exp_t e;
            resp_cnt = resp_cnt + 1;
            checks   = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_resp: got err=%0b rdata=%h with nothing pending", resp_err, resp_rdata);
            end else begin
                e = sb.pop_front();
                if (resp_err !== e.err || resp_rdata !== e.rdata || (cyc - e.acc + 1) != e.lat) begin
                    errors = errors + 1;
                    $display("FAIL %s: got err=%0b rdata=%h lat=%0d, want err=%0b rdata=%h lat=%0d",
                             e.name, resp_err, resp_rdata, cyc - e.acc + 1, e.err, e.rdata, e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic err, input logic [63:0] rd, input int lat,
                         output int acc);
        exp_t e;
        @(negedge clk);
        chk({name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc       = cyc;
        e.name    = name;
        e.err     = err;
        e.rdata   = rd;
        e.lat     = lat;
        e.acc     = acc;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run(input string name, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic err, input logic [63:0] rd, input int lat);
        int acc;
        issue(name, st, f3, a, wd, err, rd, lat, acc);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pre0, pre1;
        int          acc, w0, r0;
        pre0 = 64'hFFAAFFAAFFAAFFAA;
        pre1 = 64'h778899AABBCCDDEE;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            mem[k]     = pre0[8*k +: 8];
            mem[k + 8] = pre1[8*k +: 8];
        end
        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_wrt_en", 64'(wrt_en), 64'd0);
        chk("rst_address", address, 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Loads against the preload
        w0 = wr_cnt;
        run("ld8", 1'b0, 3'b011, 64'd8, 64'd0, 1'b0, 64'h778899AABBCCDDEE, 2);
        chk("ld8_no_write", 64'(wr_cnt - w0), 64'd0);
        run("lb1",  1'b0, 3'b000, 64'd1, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2);
        run("lbu0", 1'b0, 3'b100, 64'd0, 64'd0, 1'b0, 64'h00000000000000AA, 2);
        run("lw8",  1'b0, 3'b010, 64'd8, 64'd0, 1'b0, 64'hFFFFFFFFBBCCDDEE, 2);
        run("lwu8", 1'b0, 3'b110, 64'd8, 64'd0, 1'b0, 64'h00000000BBCCDDEE, 2);
        run("lh8",  1'b0, 3'b001, 64'd8, 64'd0, 1'b0, 64'hFFFFFFFFFFFFDDEE, 2);
        run("lhu8", 1'b0, 3'b101, 64'd8, 64'd0, 1'b0, 64'h000000000000DDEE, 2);

        // SH: single write strobe in the 2nd cycle, response in the 3rd
        w0 = wr_cnt;
        issue("sh8", 1'b1, 3'b001, 64'd8, 64'h1122334455667788, 1'b0, 64'd0, 3, acc);
        drain("sh8");
        chk("sh8_writes", 64'(wr_cnt - w0), 64'd1);
        chk("sh8_wr_cycle", 64'(last_wr_cyc - acc + 1), 64'd2);
        run("ld8_after_sh", 1'b0, 3'b011, 64'd8, 64'd0, 1'b0, 64'h778899AABBCC7788, 2);

        // SD: direct write, response in the 2nd cycle
        w0 = wr_cnt;
        run("sd16", 1'b1, 3'b011, 64'd16, 64'h1122334455667788, 1'b0, 64'd0, 2);
        chk("sd16_writes", 64'(wr_cnt - w0), 64'd1);
        run("ld16", 1'b0, 3'b011, 64'd16, 64'd0, 1'b0, 64'h1122334455667788, 2);
        run("ld0_after_sd", 1'b0, 3'b011, 64'd0, 64'd0, 1'b0, 64'hFFAAFFAAFFAAFFAA, 2);
        run("ld8_after_sd", 1'b0, 3'b011, 64'd8, 64'd0, 1'b0, 64'h778899AABBCC7788, 2);

        // SW: merge of low 4 bytes, surrounding bytes preserved
        run("sw20", 1'b1, 3'b010, 64'd20, 64'hCAFEBABE12345678, 1'b0, 64'd0, 3);
        run("ld16_after_sw", 1'b0, 3'b011, 64'd16, 64'd0, 1'b0, 64'h1234567855667788, 2);

        // Error cases: no memory access
        w0 = wr_cnt;
        run("ill_ld", 1'b0, 3'b111, 64'd8, 64'd0, 1'b1, 64'd0, 1);
        run("ill_st", 1'b1, 3'b111, 64'd8, 64'hDEAD, 1'b1, 64'd0, 1);
        run("ill_sbu", 1'b1, 3'b100, 64'd0, 64'hDEAD, 1'b1, 64'd0, 1);
        chk("ill_no_write", 64'(wr_cnt - w0), 64'd0);
`ifdef MISALIGN_TRAP_EN
        run("lw2_mis", 1'b0, 3'b010, 64'd2, 64'd0, 1'b1, 64'd0, 1);
`else
        run("lw2_mis", 1'b0, 3'b010, 64'd2, 64'd0, 1'b0, 64'hFFFFFFFFFFAAFFAA, 2);
`endif

        // SB aborted by reset during RMW_RD
        @(negedge clk);
        chk("abort_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 64'd0; req_wdata = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w0 = wr_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_rst_ready", 64'(req_ready), 64'd1);
        chk("abort_rst_wrt_en", 64'(wrt_en), 64'd0);
        chk("abort_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_rst_address", address, 64'd0);
        chk("abort_rst_write_data", write_data, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("abort_no_resp", 64'(resp_cnt - r0), 64'd0);
        chk("abort_ready_after", 64'(req_ready), 64'd1);
        run("ld0_after_abort", 1'b0, 3'b011, 64'd0, 64'd0, 1'b0, 64'hFFAAFFAAFFAAFFAA, 2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
